multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM controller for the multi-cycle RV32I datapath. Generalises the single-cycle opcode decoder.
//  Sequences each instruction through fetch/decode/execute/memory/writeback with a memory ready handshake.
//  Adds a memory-wait timeout, a retired-instruction counter, and a sticky trap for illegal opcodes or timeouts.
//  Sits between the instruction register (opcode field) and the shared PC/IR/ALU/regfile/memory datapath.
// PARAMETERS
//  OPCODE_W    7   opcode field width
//  ALUOP_W     2   ALUOp width (00 add, 01 sub/compare, 10 funct-decoded)
//  MEM_TIMEOUT 15  max mem_ready wait cycles per memory state; 0 = timeout disabled
//  CNT_W       32  width of instr_retired
// PORTS
//  clk           in   1        single clock, rising edge
//  reset         in   1        synchronous, active-high
//  opcode        in   OPCODE_W IR[6:0], valid from DECODE onward
//  mem_ready     in   1        memory completes access this cycle
//  PCWrite       out  1        unconditional PC load
//  PCWriteCond   out  1        PC load if ALU zero (beq)
//  IorD          out  1        0 = PC addresses memory, 1 = ALUOut
//  MemRead       out  1
//  MemWrite      out  1
//  IRWrite       out  1
//  MemtoReg      out  1        1 = MDR to regfile, 0 = ALUOut
//  RegWrite      out  1
//  ALUSrcA       out  1        0 = PC, 1 = rs1
//  ALUSrcB       out  2        00 rs2, 01 const 4, 10 imm
//  ALUOp         out  ALUOP_W
//  PCSource      out  2        00 ALU result, 01 ALUOut, 10 jump target
//  trap          out  1        sticky error; cleared only by reset
//  instr_retired out  CNT_W    count of completed instructions
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP.
//  Reset: state=IDLE, wait counter=0, instr_retired=0. In IDLE all outputs are 0. IDLE->FETCH unconditionally.
//  FETCH:     MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
//             IRWrite and PCWrite are asserted only in the mem_ready cycle. Then ->DECODE; otherwise stay.
//  DECODE:    ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
//             Next state by opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADDR, 1100011->BRANCH.
//             Any other opcode ->TRAP.
//  MEM_ADDR:  ALUSrcA=1, ALUSrcB=10, ALUOp=00. Load ->MEM_READ; store ->MEM_WRITE.
//  MEM_READ:  MemRead=1, IorD=1. Waits for mem_ready, then ->MEM_WB.
//  MEM_WRITE: MemWrite=1, IorD=1. Waits for mem_ready, then ->FETCH.
//  MEM_WB:    RegWrite=1, MemtoReg=1. ->FETCH.
//  EXEC_R:    ALUSrcA=1, ALUSrcB=00, ALUOp=10. ->ALU_WB.
//  EXEC_I:    ALUSrcA=1, ALUSrcB=10, ALUOp=10. ->ALU_WB.
//  ALU_WB:    RegWrite=1, MemtoReg=0. ->FETCH.
//  BRANCH:    ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. ->FETCH.
//  TRAP:      all controls 0, trap=1. Stays in TRAP until reset.
//  Latency with zero wait states: beq 3, R/I/sw 4, lw 5 cycles.
//  Every signal not listed for a state is 0.
//  Wait counter: cleared on entry to FETCH/MEM_READ/MEM_WRITE; +1 per cycle with mem_ready=0.
//    If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT while mem_ready=0 -> TRAP. No memory strobe that cycle.
//    If mem_ready=1 in the same cycle the counter reaches the limit, completion wins.
//  instr_retired: +1 on each transition into FETCH from MEM_WRITE, MEM_WB, ALU_WB or BRANCH. Wraps modulo 2^CNT_W.
//  Reset mid-instruction: the instruction is abandoned, no strobe is issued, and the FSM returns to IDLE.
// CONFIGURATION
//  MC_JUMP_EN defined: adds states JAL_EXEC and JALR_EXEC.
//    DECODE routes 1101111->JAL_EXEC and 1100111->JALR_EXEC.
//    Each asserts PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=0; ALUSrcA=0 for jal, 1 for jalr; then ->FETCH and counts as retired.
//  MC_JUMP_EN undefined: those opcodes trap as illegal; PCSource=10 is never driven.
// STRUCTURE
//  Package mc_ctrl_pkg holds:
//    the state_t enum;
//    opcode localparams (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR);
//    ALUOp / ALUSrcB / PCSource encodings.
//  Sub-module mc_wait_timer: the wait counter and timeout compare. Inputs: clk, reset, start, ready. Output: expired.
//  The FSM uses a registered state and a combinational output decode.
// TESTING
//  1. Reset, then addi (0010011) with mem_ready=1 -> IDLE,FETCH,DECODE,EXEC_I,ALU_WB; RegWrite=1 in cycle 5; instr_retired=1.
//  2. lw, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles; MemRead=1, IorD=1 throughout; then MEM_WB with MemtoReg=1.
//  3. beq -> BRANCH asserts PCWriteCond=1, ALUOp=01, PCSource=01; back in FETCH 3 cycles after FETCH.
//  4. Opcode 0000000 -> TRAP after DECODE; trap stays 1 for 20 cycles with mem_ready toggling; reset clears it.
//  5. MEM_TIMEOUT=15, mem_ready held 0 in MEM_WRITE -> TRAP after 15 wait cycles; MemWrite is 0 on the trap cycle.
//  6. Reset asserted in MEM_WRITE -> next cycle IDLE, all outputs 0, instr_retired=0; with MC_JUMP_EN, jal -> PCWrite=1, PCSource=10, RegWrite=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// Jump states exist only when MC_JUMP_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
`ifdef MC_JUMP_EN
    JAL_EXEC,
    JALR_EXEC,
`endif
    TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

  function automatic logic is_wait_state(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master = controller, slave = datapath/memory side.
interface multicycle_control_if #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [1:0]          PCSource;
  logic                trap;
  logic [CNT_W-1:0]    instr_retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, RegWrite, ALUSrcA,
    output ALUSrcB, ALUOp, PCSource,
    output trap, instr_retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegWrite, ALUSrcA,
    input  ALUSrcB, ALUOp, PCSource,
    input  trap, instr_retired
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: cleared on start, counts not-ready cycles,
// flags expiry when the limit is hit while memory is still busy.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt;

  // Saturates at the limit so it never wraps while parked outside waits.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cnt <= '0;
    end else if (!ready && (cnt != LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && !ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM controller for the multi-cycle RV32I datapath.
// Optional jal/jalr support is enabled by defining MC_JUMP_EN.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_t state;
  state_t next;
  ctrl_t  c;
  logic   expired;
  logic   start;
  logic   retire;
  logic   ready;
  logic [CNT_W-1:0] retired;
  logic [OPCODE_W-1:0] op;

  assign ready = bus.mem_ready;
  assign op    = bus.opcode;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ready   (ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        if (ready)        next = DECODE;
        else if (expired) next = TRAP;
      end
      DECODE: begin
        unique case (1'b1)
          (op == OPCODE_W'(OP_RTYPE)): next = EXEC_R;
          (op == OPCODE_W'(OP_ITYPE)): next = EXEC_I;
          (op == OPCODE_W'(OP_LOAD)),
          (op == OPCODE_W'(OP_STORE)): next = MEM_ADDR;
          (op == OPCODE_W'(OP_BRANCH)): next = BRANCH;
`ifdef MC_JUMP_EN
          (op == OPCODE_W'(OP_JAL)):  next = JAL_EXEC;
          (op == OPCODE_W'(OP_JALR)): next = JALR_EXEC;
`endif
          default: next = TRAP;
        endcase
      end
      MEM_ADDR: begin
        if (op == OPCODE_W'(OP_LOAD)) next = MEM_READ;
        else                          next = MEM_WRITE;
      end
      MEM_READ: begin
        if (ready)        next = MEM_WB;
        else if (expired) next = TRAP;
      end
      MEM_WRITE: begin
        if (ready)        next = FETCH;
        else if (expired) next = TRAP;
      end
      MEM_WB:    next = FETCH;
      EXEC_R:    next = ALU_WB;
      EXEC_I:    next = ALU_WB;
      ALU_WB:    next = FETCH;
      BRANCH:    next = FETCH;
`ifdef MC_JUMP_EN
      JAL_EXEC:  next = FETCH;
      JALR_EXEC: next = FETCH;
`endif
      TRAP:      next = TRAP;
      default:   next = TRAP;
    endcase
  end

  assign start = (next != state) && is_wait_state(next);

  always_comb begin
    retire = 1'b0;
    case (state)
      MEM_WRITE,
      MEM_WB,
      ALU_WB,
`ifdef MC_JUMP_EN
      JAL_EXEC,
      JALR_EXEC,
`endif
      BRANCH:  retire = (next == FETCH);
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Strobes are suppressed on a timeout cycle and while reset is held.
  always_comb begin
    c = '0;
    case (state)
      FETCH: begin
        c.mem_read  = !expired;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.ir_write  = ready;
        c.pc_write  = ready;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        c.mem_read = !expired;
        c.iord     = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = !expired;
        c.iord      = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      ALU_WB: begin
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RS2;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
      end
`ifdef MC_JUMP_EN
      JAL_EXEC: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
        c.reg_write = 1'b1;
      end
      JALR_EXEC: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
        c.reg_write = 1'b1;
        c.alu_src_a = 1'b1;
      end
`endif
      TRAP: begin
        c.trap = 1'b1;
      end
      default: c = '0;
    endcase
    if (reset) c = '0;
  end

  assign bus.PCWrite       = c.pc_write;
  assign bus.PCWriteCond   = c.pc_write_cond;
  assign bus.IorD          = c.iord;
  assign bus.MemRead       = c.mem_read;
  assign bus.MemWrite      = c.mem_write;
  assign bus.IRWrite       = c.ir_write;
  assign bus.MemtoReg      = c.mem_to_reg;
  assign bus.RegWrite      = c.reg_write;
  assign bus.ALUSrcA       = c.alu_src_a;
  assign bus.ALUSrcB       = c.alu_src_b;
  assign bus.ALUOp         = ALUOP_W'(c.alu_op);
  assign bus.PCSource      = c.pc_source;
  assign bus.trap          = c.trap;
  assign bus.instr_retired = retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control
// words and retire counts flow through a scoreboard queue.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if #(
    .OPCODE_W (7),
    .ALUOP_W  (2),
    .CNT_W    (32)
  ) bus ();

  multicycle_control #(
    .OPCODE_W    (7),
    .ALUOP_W     (2),
    .MEM_TIMEOUT (15),
    .CNT_W       (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPJ = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;
  localparam logic [6:0] OPX = 7'b0000000;

  // {pcw,pcwc,iord,mr,mw,irw,m2r,rw,srca,srcb,aluop,pcsrc,trap}
  function automatic logic [15:0] mk(
    input logic pcw, input logic pcwc, input logic iord,
    input logic mr, input logic mw, input logic irw,
    input logic m2r, input logic rw, input logic sa,
    input logic [1:0] sb, input logic [1:0] ao,
    input logic [1:0] ps, input logic tr);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw,
            sa, sb, ao, ps, tr};
  endfunction

  localparam logic [15:0] E_IDLE =
    mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] E_FW =
    mk(0,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0);
  localparam logic [15:0] E_FR =
    mk(1,0,0,1,0,1,0,0,0,2'b01,2'b00,2'b00,0);
  localparam logic [15:0] E_DEC =
    mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0);
  localparam logic [15:0] E_MA =
    mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
  localparam logic [15:0] E_MRD =
    mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] E_MWR =
    mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] E_MWTO =
    mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] E_MWB =
    mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] E_EXR =
    mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
  localparam logic [15:0] E_EXI =
    mk(0,0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,0);
  localparam logic [15:0] E_AWB =
    mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] E_BR =
    mk(0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
  localparam logic [15:0] E_TRAP =
    mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);
  localparam logic [15:0] E_JAL =
    mk(1,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b10,0);
  localparam logic [15:0] E_JALR =
    mk(1,0,0,0,0,0,0,1,1,2'b00,2'b00,2'b10,0);

  typedef struct {
    logic [15:0] ctl;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          checks;
  int          errors;
  logic [31:0] exp_ret;

  function automatic logic [15:0] observed();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.trap};
  endfunction

  task automatic cyc(input string tag, input logic rst,
                     input logic [6:0] op, input logic rdy,
                     input logic [15:0] e, input bit ret);
    exp_t x;
    @(negedge clk);
    reset = rst;
    bus.opcode = op;
    bus.mem_ready = rdy;
    sbq.push_back('{e, exp_ret, tag});
    #1;
    x = sbq.pop_front();
    checks++;
    assert (observed() === x.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed %b expected %b",
             x.tag, observed(), x.ctl);
    end
    checks++;
    assert (bus.instr_retired === x.ret) else begin
      errors++;
      $error("FAIL %s retired observed %0d expected %0d",
             x.tag, bus.instr_retired, x.ret);
    end
    if (rst) exp_ret = '0;
    else if (ret) exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_ret = '0;
    reset = 1'b1;
    bus.opcode = OPX;
    bus.mem_ready = 1'b0;

    cyc("rst0", 1, OPX, 0, E_IDLE, 0);
    cyc("rst1", 1, OPX, 1, E_IDLE, 0);

    cyc("addi_idle", 0, OPI, 1, E_IDLE, 0);
    cyc("addi_fetch", 0, OPI, 1, E_FR, 0);
    cyc("addi_dec", 0, OPI, 1, E_DEC, 0);
    cyc("addi_exec", 0, OPI, 1, E_EXI, 0);
    cyc("addi_wb", 0, OPI, 1, E_AWB, 1);

    cyc("lw_fetch", 0, OPL, 1, E_FR, 0);
    cyc("lw_dec", 0, OPL, 1, E_DEC, 0);
    cyc("lw_addr", 0, OPL, 1, E_MA, 0);
    for (int i = 0; i < 3; i++)
      cyc("lw_wait", 0, OPL, 0, E_MRD, 0);
    cyc("lw_read", 0, OPL, 1, E_MRD, 0);
    cyc("lw_wb", 0, OPL, 1, E_MWB, 1);

    cyc("beq_fetch", 0, OPB, 1, E_FR, 0);
    cyc("beq_dec", 0, OPB, 1, E_DEC, 0);
    cyc("beq_br", 0, OPB, 1, E_BR, 1);
    cyc("beq_back_wait", 0, OPR, 0, E_FW, 0);

    cyc("r_fetch", 0, OPR, 1, E_FR, 0);
    cyc("r_dec", 0, OPR, 1, E_DEC, 0);
    cyc("r_exec", 0, OPR, 1, E_EXR, 0);
    cyc("r_wb", 0, OPR, 1, E_AWB, 1);

    cyc("sw_fetch", 0, OPS, 1, E_FR, 0);
    cyc("sw_dec", 0, OPS, 1, E_DEC, 0);
    cyc("sw_addr", 0, OPS, 1, E_MA, 0);
    for (int i = 0; i < 15; i++)
      cyc("sw_wait", 0, OPS, 0, E_MWR, 0);
    cyc("sw_limit_done", 0, OPS, 1, E_MWR, 1);

    cyc("rst_fetch", 0, OPS, 1, E_FR, 0);
    cyc("rst_dec", 0, OPS, 1, E_DEC, 0);
    cyc("rst_addr", 0, OPS, 1, E_MA, 0);
    cyc("rst_mwr", 0, OPS, 0, E_MWR, 0);
    cyc("rst_in_mwr", 1, OPS, 1, E_IDLE, 0);
    cyc("rst_idle", 0, OPS, 1, E_IDLE, 0);

    cyc("j_fetch", 0, OPJ, 1, E_FR, 0);
    cyc("j_dec", 0, OPJ, 1, E_DEC, 0);
`ifdef MC_JUMP_EN
    cyc("jal_exec", 0, OPJ, 1, E_JAL, 1);
    cyc("jr_fetch", 0, OPJR, 1, E_FR, 0);
    cyc("jr_dec", 0, OPJR, 1, E_DEC, 0);
    cyc("jalr_exec", 0, OPJR, 1, E_JALR, 1);
`else
    cyc("jal_trap", 0, OPJ, 1, E_TRAP, 0);
    cyc("jal_rst", 1, OPJ, 1, E_IDLE, 0);
    cyc("jal_idle", 0, OPJR, 1, E_IDLE, 0);
    cyc("jr_fetch", 0, OPJR, 1, E_FR, 0);
    cyc("jr_dec", 0, OPJR, 1, E_DEC, 0);
    cyc("jalr_trap", 0, OPJR, 1, E_TRAP, 0);
    cyc("jalr_rst", 1, OPJR, 1, E_IDLE, 0);
    cyc("jalr_idle", 0, OPS, 1, E_IDLE, 0);
`endif

    cyc("to_fetch", 0, OPS, 1, E_FR, 0);
    cyc("to_dec", 0, OPS, 1, E_DEC, 0);
    cyc("to_addr", 0, OPS, 1, E_MA, 0);
    for (int i = 0; i < 15; i++)
      cyc("to_wait", 0, OPS, 0, E_MWR, 0);
    cyc("to_expire", 0, OPS, 0, E_MWTO, 0);
    for (int i = 0; i < 3; i++)
      cyc("to_trap", 0, OPS, i[0], E_TRAP, 0);
    cyc("to_rst", 1, OPS, 0, E_IDLE, 0);
    cyc("to_idle", 0, OPX, 1, E_IDLE, 0);

    cyc("ill_fetch", 0, OPX, 1, E_FR, 0);
    cyc("ill_dec", 0, OPX, 1, E_DEC, 0);
    for (int i = 0; i < 20; i++)
      cyc("ill_trap", 0, OPX, i[0], E_TRAP, 0);
    cyc("ill_rst", 1, OPX, 1, E_IDLE, 0);
    cyc("ill_idle", 0, OPI, 1, E_IDLE, 0);
    cyc("ill_fetch2", 0, OPI, 0, E_FW, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
